// File: rtl/multi_div.sv
// 8-bit by 4-bit unsigned restoring divider, one quotient bit per clock.
// Define MULTI_DIV_ZERO_CHECK_EN to finish a divide-by-zero one edge after start, with dz set.
module multi_div (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       dz
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [3:0] rem;
    logic [6:0] qacc;
    logic [2:0] count;
    logic [4:0] shifted;
    logic [3:0] rem_next;
    logic       fit;
    logic       zero_skip;
    logic       last;

    // The stored remainder is always below the divisor, so its low four bits after
    // subtraction are exact; only the 5-bit shifted value needs the compare.
    always_comb begin
        shifted  = {rem, dvd[7]};
        fit      = (shifted >= {1'b0, dvs});
        rem_next = fit ? (shifted[3:0] - dvs) : shifted[3:0];
`ifdef MULTI_DIV_ZERO_CHECK_EN
        zero_skip = (dvs == 4'h0);
`else
        zero_skip = 1'b0;
`endif
        last = (count == 3'd7) || zero_skip;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == BUSY);

`ifdef MULTI_DIV_ZERO_CHECK_EN
    logic dz_q;
    assign dz = dz_q;
`else
    assign dz = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            qacc      <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
`ifdef MULTI_DIV_ZERO_CHECK_EN
            dz_q      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd   <= dividend;
                        dvs   <= divisor;
                        rem   <= '0;
                        qacc  <= '0;
                        count <= '0;
                    end
                end
                BUSY: begin
                    dvd   <= {dvd[6:0], 1'b0};
                    rem   <= rem_next;
                    qacc  <= {qacc[5:0], fit};
                    count <= count + 3'd1;
                    // Early zero exit still sees the untouched dividend in dvd.
                    if (last) begin
                        done      <= 1'b1;
                        quotient  <= zero_skip ? 8'hFF : {qacc, fit};
                        remainder <= zero_skip ? dvd[3:0] : rem_next;
`ifdef MULTI_DIV_ZERO_CHECK_EN
                        dz_q      <= zero_skip;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multi_div.md
MULTI_DIV -- requirements
Module: multi_div

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, 8 bits: unsigned numerator, captured at the edge that accepts start.
REQ-006 The block SHALL have port divisor, input, 4 bits: unsigned denominator, captured with dividend.
REQ-007 The block SHALL have port quotient, output, 8 bits: unsigned result, registered.
REQ-008 The block SHALL have port remainder, output, 4 bits: unsigned result, registered.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid quotient/remainder.
REQ-011 The block SHALL have port dz, output, 1 bit: divide-by-zero flag, registered alongside done.

Function
REQ-012 The FSM SHALL have states IDLE and BUSY; it leaves reset in IDLE.
REQ-013 In IDLE with start=1 at edge E0, the block SHALL capture its operands, clear the partial remainder, enter BUSY and set busy=1.
REQ-014 BUSY SHALL use restoring division, MSB first, one quotient bit per edge: shift the next dividend bit into the 5-bit partial remainder; if partial >= divisor, subtract and set the quotient bit to 1, else set it to 0.
REQ-015 Eight iterations SHALL occur at edges E1..E8; at E8 the block SHALL load quotient and remainder, set done=1, clear busy and return to IDLE.
REQ-016 done SHALL be high for exactly one cycle and clear at the next edge unless a new result completes at that edge.
REQ-017 quotient, remainder and dz SHALL hold their last values until the next completion or reset.
REQ-018 start while BUSY SHALL be ignored: operands are not re-captured and the timing of the operation in flight is unchanged.
REQ-019 A start sampled at the edge following the one that set done (state IDLE, done=1) SHALL be accepted normally, so back-to-back operations are possible.
REQ-020 Input operands SHALL be don't-care except at the accepting edge; changes during BUSY SHALL NOT affect the result.
REQ-021 For divisor != 0, the results SHALL satisfy quotient*divisor + remainder == dividend, with remainder < divisor.
REQ-022 For any operands, latency from the start edge to done SHALL be 8 edges, except in the case given in REQ-027.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE with busy=0, done=0, dz=0, quotient=8'h00, remainder=4'h0 and all internal registers cleared.
REQ-024 Reset mid-operation SHALL abort the operation with no done pulse; rst takes priority over start at the same edge.
REQ-025 The first start after rst deasserts SHALL be accepted at the first edge with rst=0.

Configuration
REQ-026 The macro MULTI_DIV_ZERO_CHECK_EN SHALL select whether divide-by-zero is detected early.
REQ-027 With MULTI_DIV_ZERO_CHECK_EN defined, divisor=0 at the start edge SHALL skip BUSY iterations and produce, at edge E1, done=1, dz=1, quotient=8'hFF and remainder=dividend[3:0].
REQ-028 With MULTI_DIV_ZERO_CHECK_EN undefined, divisor=0 SHALL run the normal 8 iterations and yield quotient=8'hFF and remainder=dividend[3:0] at E8, with dz tied to 0.
REQ-029 The port list SHALL be identical in both configurations.

Verification
REQ-030 The bench SHALL cover a basic divide: dividend=36 (8'h24), divisor=6 -> done 8 edges after start, quotient=6, remainder=0, dz=0.
REQ-031 The bench SHALL cover a divide with nonzero remainder: dividend=200, divisor=7 -> quotient=28, remainder=4; also 255/1 -> quotient=255, remainder=0.
REQ-032 The bench SHALL cover back-to-back operations: 35/5 then 49/7 with start held high -> two done pulses 9 edges apart with results 7 r0 and 7 r0.
REQ-033 The bench SHALL cover start during BUSY: start 35/5, then pulse start with 12/3 at E4 -> single done at E8 with quotient=7, remainder=0.
REQ-034 The bench SHALL cover reset mid-operation: rst at E5 -> no done pulse and all outputs zero; the next 24/6 -> quotient=4, remainder=0.
REQ-035 The bench SHALL cover divide-by-zero: 100/0 -> macro defined: done at E1, dz=1, quotient=8'hFF, remainder=4'h4; macro undefined: done at E8, dz=0, quotient=8'hFF, remainder=4'h4.
